// File: rtl/three_bit.sv
// three_bit: registered 3-bit ripple-carry adder with bit-level operand and result ports
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p, g, t;
  half_adder u_ha0 (.a(a), .b(b), .s(p), .c(g));
  half_adder u_ha1 (.a(p), .b(cin), .s(s), .c(t));
  assign cout = g | t;
endmodule

module three_bit (
  input  logic clk,
  input  logic rst_n,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic cout,
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic y0,
  input  logic y1,
  input  logic y2
);
  logic [2:0] sum, c;
  logic [3:0] res_d, res_q;
  full_adder u_fa0 (.a(x0), .b(y0), .cin(1'b0), .s(sum[0]), .cout(c[0]));
  full_adder u_fa1 (.a(x1), .b(y1), .cin(c[0]), .s(sum[1]), .cout(c[1]));
  full_adder u_fa2 (.a(x2), .b(y2), .cin(c[1]), .s(sum[2]), .cout(c[2]));
  always_comb begin
    res_d = {c[2], sum};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= 4'd0;
    else        res_q <= res_d;
  end
  assign {cout, s2, s1, s0} = res_q;
endmodule

// File: tb/tb_three_bit.sv
// tb_three_bit: directed and exhaustive checks of three_bit against an arithmetic reference
module tb_three_bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] xv = 3'd0, yv = 3'd0;
  logic s0, s1, s2, cout;
  logic [3:0] exp_q = 4'd0;
  logic [3:0] dout;
  int checks = 0, errors = 0;

  three_bit dut (
    .clk(clk), .rst_n(rst_n),
    .s0(s0), .s1(s1), .s2(s2), .cout(cout),
    .x0(xv[0]), .x1(xv[1]), .x2(xv[2]),
    .y0(yv[0]), .y1(yv[1]), .y2(yv[2])
  );

  assign dout = {cout, s2, s1, s0};

  always #5 clk = ~clk;

  // Reference: the previous edge's x+y, forced to zero whenever reset is low
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= 4'd0;
    else        exp_q <= 4'({1'b0, xv} + {1'b0, yv});
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got cout=%b s=%0d, expected cout=%b s=%0d", nm, act[3], act[2:0], want[3], want[2:0]);
    end
  endtask

  always @(negedge clk) chk("model", dout, exp_q);

  task automatic vec(input string nm, input logic [2:0] x, input logic [2:0] y,
                     input logic [2:0] s, input logic co);
    xv = x;
    yv = y;
    @(posedge clk);
    #1 chk(nm, dout, {co, s});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    xv = 3'd7;
    yv = 3'd7;
    repeat (3) @(posedge clk);
    #1 chk("reset_hold", dout, 4'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("reset_release", dout, {1'b1, 3'd6});
    vec("5+2", 3'd5, 3'd2, 3'd7, 1'b0);
    vec("3+4", 3'd3, 3'd4, 3'd7, 1'b0);
    vec("6+3", 3'd6, 3'd3, 3'd1, 1'b1);
    vec("7+3", 3'd7, 3'd3, 3'd2, 1'b1);
    vec("7+1", 3'd7, 3'd1, 3'd0, 1'b1);
    vec("0+0", 3'd0, 3'd0, 3'd0, 1'b0);
    vec("4+4", 3'd4, 3'd4, 3'd0, 1'b1);
    vec("7+7", 3'd7, 3'd7, 3'd6, 1'b1);
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        xv = 3'(x);
        yv = 3'(y);
        @(posedge clk);
        #1;
      end
    vec("6+3_pre_rst", 3'd6, 3'd3, 3'd1, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", dout, 4'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("after_async_rst", dout, {1'b1, 3'd1});
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
